// File: rtl/aq_djpeg_mcu_buf.sv
// aq_djpeg_mcu_buf
// Multi-bank MCU reorder buffer between the IDCT and the colour converter.
// The IDCT writes 8x8 component blocks one sample per cycle. The colour
// converter reads raster pixels of a complete MCU, and chroma is upsampled
// by address replication.
// Optional feature macro: AQ_DJPEG_MCU_BUF_ERR_EN enables the sticky
// overflow/underflow flags. Without it both flags are tied to 0.
module aq_djpeg_mcu_buf #(
    parameter int DW    = 9,
    parameter int BANKS = 4
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          DataInit,
    input  logic [1:0]    Mode,
    input  logic          DataInEnable,
    output logic          DataInReady,
    input  logic [2:0]    DataInBlock,
    input  logic [5:0]    DataInAddress,
    input  logic [DW-1:0] DataIn,
    output logic          DataOutEnable,
    input  logic          DataOutRead,
    input  logic [7:0]    DataOutAddress,
    output logic          DataOutValid,
    output logic [DW-1:0] DataOutY,
    output logic [DW-1:0] DataOutCb,
    output logic [DW-1:0] DataOutCr,
    output logic          ErrOverflow,
    output logic          ErrUnderflow
);

    localparam int             PW     = $clog2(BANKS);
    localparam logic [PW:0]    C_FULL = (PW+1)'(BANKS);

    typedef enum logic [1:0] {
        MODE_444 = 2'd0,
        MODE_422 = 2'd1,
        MODE_420 = 2'd2
    } mode_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    mode_t         r_mode;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_fill;

    logic          w_wr;
    logic          w_rd;
    logic          w_commit;
    logic          w_release;
    logic [7:0]    w_last_px;
    logic [5:0]    w_c_raddr;
    logic [7:0]    w_y_waddr;

    // Per-bank storage, bank index in the upper address bits.
    logic [DW-1:0] r_ram_y  [0:BANKS*256-1];
    logic [DW-1:0] r_ram_cb [0:BANKS*64-1];
    logic [DW-1:0] r_ram_cr [0:BANKS*64-1];

    assign DataInReady   = (r_fill != C_FULL);
    assign DataOutEnable = (r_fill != '0);

    // DataInit outranks everything, so it also masks both strobes.
    assign w_wr      = DataInEnable & DataInReady & ~DataInit;
    assign w_rd      = DataOutRead & DataOutEnable & ~DataInit;
    assign w_commit  = w_wr & (DataInBlock == 3'd5) & (DataInAddress == 6'd63);
    assign w_release = w_rd & (DataOutAddress == w_last_px);

    // Y blocks tile the 16x16 plane: block bit 1 picks the row half and
    // block bit 0 picks the column half.
    assign w_y_waddr = {DataInBlock[1], DataInAddress[5:3],
                        DataInBlock[0], DataInAddress[2:0]};

    // Mode-dependent chroma read address and last-pixel index.
    always_comb begin
        w_c_raddr = {DataOutAddress[6:4], DataOutAddress[2:0]};
        w_last_px = 8'h77;
        case (r_mode)
            MODE_422: begin
                w_c_raddr = {DataOutAddress[6:4], DataOutAddress[3:1]};
                w_last_px = 8'h7F;
            end
            MODE_420: begin
                w_c_raddr = {DataOutAddress[7:5], DataOutAddress[3:1]};
                w_last_px = 8'hFF;
            end
            default: begin
                w_c_raddr = {DataOutAddress[6:4], DataOutAddress[2:0]};
                w_last_px = 8'h77;
            end
        endcase
    end

    // Latch the sampling mode on restart; the reserved code falls back to 4:4:4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= MODE_444;
        end else if (DataInit) begin
            r_mode <= (Mode == 2'd3) ? MODE_444 : mode_t'(Mode);
        end
    end

    // Bank pointers and fill count. A simultaneous commit and release cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else if (DataInit) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_commit) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_release) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_commit && !w_release) begin
                r_fill <= r_fill + (PW+1)'(1);
            end else if (!w_commit && w_release) begin
                r_fill <= r_fill - (PW+1)'(1);
            end
        end
    end

    // Sample writes into the current write bank; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (!DataInBlock[2]) begin
                r_ram_y[{r_wptr, w_y_waddr}] <= DataIn;
            end
            if (DataInBlock == 3'd4) begin
                r_ram_cb[{r_wptr, DataInAddress}] <= DataIn;
            end
            if (DataInBlock == 3'd5) begin
                r_ram_cr[{r_wptr, DataInAddress}] <= DataIn;
            end
        end
    end

    // Registered read port. The data holds while no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DataOutValid <= 1'b0;
            DataOutY     <= '0;
            DataOutCb    <= '0;
            DataOutCr    <= '0;
        end else begin
            DataOutValid <= w_rd;
            if (w_rd) begin
                DataOutY  <= r_ram_y[{r_rptr, DataOutAddress}];
                DataOutCb <= r_ram_cb[{r_rptr, w_c_raddr}];
                DataOutCr <= r_ram_cr[{r_rptr, w_c_raddr}];
            end
        end
    end

`ifdef AQ_DJPEG_MCU_BUF_ERR_EN
    logic r_err_ovf;
    logic r_err_unf;

    // Sticky protocol errors: a write while full, or a read while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (DataInit) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (DataInEnable && !DataInReady) begin
                r_err_ovf <= 1'b1;
            end
            if (DataOutRead && !DataOutEnable) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign ErrOverflow  = r_err_ovf;
    assign ErrUnderflow = r_err_unf;
`else
    assign ErrOverflow  = 1'b0;
    assign ErrUnderflow = 1'b0;
`endif

endmodule

// File: doc/aq_djpeg_mcu_buf.md
# aq_djpeg_mcu_buf

Parametrised multi-bank MCU reorder buffer between the IDCT and the colour-space converter of the JPEG decoder. It accepts 8x8 component blocks (Y, Cb, Cr) one sample per cycle and presents them as raster pixels of one MCU. Chroma is upsampled by address replication for 4:4:4, 4:2:2 and 4:2:0 sampling. A configurable number of banks lets IDCT writes and colour-conversion reads proceed concurrently.

## Interface
- DW, 9, sample width in bits
- BANKS, 4, number of MCU banks; power of two, at least 2
- rst  in  1  reset, asynchronous, active-low
- clk  in  1  clock
- DataInit  in  1  synchronous restart; clears pointers, fill count and error flags; latches Mode
- Mode  in  2  sampling mode: 0 = 4:4:4 (8x8 MCU), 1 = 4:2:2 (16x8), 2 = 4:2:0 (16x16), 3 = reserved (treated as 0)
- DataInEnable  in  1  write strobe
- DataInReady  out  1  a bank is free for writing
- DataInBlock  in  3  0-3 = Y0..Y3, 4 = Cb, 5 = Cr
- DataInAddress  in  6  raster index within the block, {row[2:0], col[2:0]}
- DataIn  in  DW  sample
- DataOutEnable  out  1  at least one complete MCU is held
- DataOutRead  in  1  read strobe
- DataOutAddress  in  8  MCU pixel, {y[3:0], x[3:0]}
- DataOutValid  out  1  read data valid
- DataOutY, DataOutCb, DataOutCr  out  DW each  pixel components
- ErrOverflow, ErrUnderflow  out  1 each  sticky error flags (see Configuration)

## Operation
- Storage per bank: Y 256 x DW, Cb 64 x DW, Cr 64 x DW. Inferred synchronous RAM, no reset on contents.
- Y write address: {DataInBlock[1], row, DataInBlock[0], col}. Cb/Cr write address: {row, col}.
- Blocks per MCU: 4:4:4 = Y0, Cb, Cr. 4:2:2 = Y0, Y1, Cb, Cr. 4:2:0 = Y0..Y3, Cb, Cr.
- A bank commits on an accepted write with DataInBlock = 5 and DataInAddress = 63. The write pointer then advances modulo BANKS.
- Accepted write = DataInEnable & DataInReady. A write while not ready is dropped.
- Chroma read address: 4:4:4 = {y[2:0], x[2:0]}; 4:2:2 = {y[2:0], x[3:1]}; 4:2:0 = {y[3:1], x[3:1]}. Y read address = DataOutAddress.
- Last pixel of an MCU: 0x77 (4:4:4), 0x7F (4:2:2), 0xFF (4:2:0).
- Accepted read = DataOutRead & DataOutEnable. An accepted read of the last pixel releases the bank, and the read pointer advances modulo BANKS.
- FillCount is log2(BANKS)+1 bits wide:
  - +1 on commit, -1 on release.
  - Commit and release in the same cycle leave it unchanged.
  - Pointers wrap naturally.
- DataOutEnable = (FillCount != 0). DataInReady = (FillCount != BANKS).
- DataInit has priority over everything in the same cycle. The latched Mode is held until the next DataInit.

## Timing
- Every output resets to 0 except DataInReady, which resets to 1.
- Read latency is 1 cycle. DataOutValid, DataOutY, DataOutCb and DataOutCr are registered. Data holds its last value when DataOutValid = 0.
- A commit at edge N makes DataOutEnable = 1 after edge N.
- The last-pixel read at edge N makes FillCount decrement after edge N. Its data is still presented valid after edge N.
- A full buffer releases at edge N; DataInReady rises after edge N, and a write is accepted at edge N+1.
- Reset mid-MCU: the partial bank is discarded.
- DataInit mid-MCU: the same as reset, except RAM contents remain. There is no read-before-write hazard, because the read and write banks differ whenever reads are allowed.

## Configuration
- AQ_DJPEG_MCU_BUF_ERR_EN:
  - Defined: ErrOverflow sets on DataInEnable while DataInReady = 0. ErrUnderflow sets on DataOutRead while DataOutEnable = 0. Both are sticky until reset or DataInit.
  - Undefined: both ports are tied to 0 and no logic is generated.

## Test plan
- Mode 2, BANKS = 4: write one MCU with sample = {block, address}. Read 0x00..0xFF. Expect pixel (x=9, y=3) gives Y = {1,0x19}, Cb = Cr = Cb/Cr sample at address 0x0C.
- Mode 0: write Y0/Cb/Cr. Read through 0x77, then an extra read. Expect DataOutEnable to drop after the 0x77 read and the extra read to be ignored.
- Mode 1: pixel 0x5F reads Y1 address 0x2F and chroma address 0x2F.
- Write 4 MCUs with no reads: DataInReady = 0 after the 4th commit. A 5th write is dropped, and ErrOverflow = 1 when the macro is defined (0 when undefined).
- A commit and a last-pixel release on the same edge with FillCount = 2: FillCount stays 2 and DataOutEnable stays 1.
- DataInit asserted mid-write with FillCount = 1: next cycle FillCount = 0, DataInReady = 1, DataOutEnable = 0, errors cleared.
